// File: rtl/okregbus_pkg.sv
// Shared types and constants for the host register-bus controller.
// No logic: FSM encoding, status bit positions, timeout read pattern.
package okregbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int ST_BUSY      = 0;
  localparam int ST_TIMEOUT   = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_LASTRD    = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [15:0] RDATA_TIMEOUT = 16'hDEAD;

endpackage

// File: rtl/okregbus_timeout.sv
// Strobe watchdog: loads TIMEOUT-1 at strobe start, counts down each strobe cycle.
// expired is high on the TIMEOUT-th strobe cycle; no backpressure.
module okregbus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 16'(TIMEOUT - 1);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/okregbus_ctrl.sv
// FrontPanel-to-register-bus bridge: one strobed transaction per trigger, done pulse ack+1.
// Triggers arriving while busy are dropped and flagged as overrun; no other backpressure.
module okregbus_ctrl
  import okregbus_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              ti_clk,
  input  logic              rst,
  input  logic [15:0]       cmd_addr,
  input  logic [15:0]       cmd_wdata,
  input  logic              trig_wr,
  input  logic              trig_rd,
  input  logic              clr_flags,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wr,
  output logic              bus_rd,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [15:0]       rdata_wire,
  output logic [15:0]       status_wire,
  output logic              done_trig
);

  state_t     state, state_next;
  logic       start_wr, start_rd, finish;
  logic       timeout_evt, overrun_evt;
  logic       expired;
  logic       op_rd;
  logic       last_rd;
  logic       flag_to, flag_ovr;
  logic [7:0] count;
  logic       unused_bits;

  assign unused_bits = ^{cmd_addr, cmd_wdata};

  okregbus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (ti_clk),
    .rst     (rst),
    .load    (start_wr | start_rd),
    .run     (state == STROBE),
    .expired (expired)
  );

  always_ff @(posedge ti_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_wr   = 1'b0;
    start_rd   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (trig_wr) begin
          start_wr   = 1'b1;
          state_next = STROBE;
        end else if (trig_rd) begin
          start_rd   = 1'b1;
          state_next = STROBE;
        end
      end
      STROBE: begin
        if (bus_ack || expired) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A simultaneous ack wins over expiry, so the flag only fires on a true timeout.
  assign timeout_evt = (state == STROBE) && expired && !bus_ack;
  assign overrun_evt = (state == IDLE) ? (trig_wr && trig_rd) : (trig_wr || trig_rd);

  always_ff @(posedge ti_clk) begin
    if (rst) begin
      bus_addr   <= '0;
      bus_wdata  <= '0;
      op_rd      <= 1'b0;
      last_rd    <= 1'b0;
      count      <= '0;
      rdata_wire <= '0;
      flag_to    <= 1'b0;
      flag_ovr   <= 1'b0;
    end else begin
      if (start_wr) begin
        bus_addr  <= cmd_addr[ADDR_W-1:0];
        bus_wdata <= cmd_wdata[DATA_W-1:0];
        op_rd     <= 1'b0;
      end
      if (start_rd) begin
        bus_addr <= cmd_addr[ADDR_W-1:0];
        op_rd    <= 1'b1;
      end
      if (finish) begin
        last_rd <= op_rd;
        count   <= count + 8'd1;
        if (op_rd) rdata_wire <= bus_ack ? 16'(bus_rdata) : RDATA_TIMEOUT;
      end
      if (timeout_evt)    flag_to <= 1'b1;
      else if (clr_flags) flag_to <= 1'b0;
      if (overrun_evt)    flag_ovr <= 1'b1;
      else if (clr_flags) flag_ovr <= 1'b0;
    end
  end

  assign bus_wr    = (state == STROBE) && !op_rd;
  assign bus_rd    = (state == STROBE) && op_rd;
  assign done_trig = (state == DONE);

  always_comb begin
    status_wire                        = '0;
    status_wire[ST_BUSY]               = (state != IDLE);
    status_wire[ST_TIMEOUT]            = flag_to;
    status_wire[ST_OVERRUN]            = flag_ovr;
    status_wire[ST_LASTRD]             = last_rd;
    status_wire[ST_COUNT_LSB +: 8]     = count;
  end

endmodule

// File: tb/tb_okregbus_ctrl.sv
// Scoreboarded bench: transaction-level model predicts each completion, monitor checks on done_trig.
module tb_okregbus_ctrl;
  import okregbus_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          ti_clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   cmd_addr = '0, cmd_wdata = '0;
  logic          trig_wr = 1'b0, trig_rd = 1'b0, clr_flags = 1'b0;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_wr, bus_rd;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic [15:0]   rdata_wire, status_wire;
  logic          done_trig;

  always #5 ti_clk = ~ti_clk;

  okregbus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .ti_clk(ti_clk), .rst(rst), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .trig_wr(trig_wr), .trig_rd(trig_rd), .clr_flags(clr_flags),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .rdata_wire(rdata_wire),
    .status_wire(status_wire), .done_trig(done_trig)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    bit            is_rd;
    int            len;
    logic [15:0]   rdata;
    logic [15:0]   status;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0, miscompares = 0;
  int   done_cnt = 0, n_exp = 0;

  // Reference state: what the host would read back after each completion
  logic [7:0]  m_count = '0;
  bit          m_to = 0, m_ovr = 0, m_lastrd = 0;
  logic [15:0] m_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts strobe cycles and checks each completion against the queue head
  int slen = 0;
  bit s_rd = 0;
  always @(negedge ti_clk) begin
    if (rst) begin
      slen = 0;
    end else begin
      if (bus_wr || bus_rd) begin
        slen++;
        s_rd = bus_rd;
        if (bus_wr && bus_rd) begin
          vectors++; miscompares++;
          $display("FAIL both_strobes: wr=%0b rd=%0b, expected one-hot", bus_wr, bus_rd);
        end
      end
      if (done_trig) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: done_trig=1, expected 0 at %0t", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("strobe_len", slen, e.len);
          chk("strobe_kind_rd", {31'd0, s_rd}, {31'd0, e.is_rd});
          chk("bus_addr", {24'd0, bus_addr}, {24'd0, e.addr});
          if (!e.is_rd) chk("bus_wdata", {16'd0, bus_wdata}, {16'd0, e.wdata});
          chk("rdata_wire", {16'd0, rdata_wire}, {16'd0, e.rdata});
          chk("status", {16'd0, status_wire}, {16'd0, e.status});
          chk("strobe_off_at_done", {31'd0, bus_wr | bus_rd}, 32'd0);
        end
        slen = 0;
      end
    end
  end

  // One transaction: k = ack strobe cycle (k > TO means no ack), plus optional
  // same-cycle collision, clear pulses and stray triggers during the strobe.
  task automatic run_txn(input bit is_rd, input logic [15:0] addr, input logic [15:0] wd,
                         input int k, input logic [15:0] rd, input bit collide,
                         input bit clr0, input int xtrig_at, input int clr_at, input bit noise);
    exp_t e;
    int   len;
    bit   timed, col;
    col   = collide && !is_rd;
    timed = (k > TO);
    len   = timed ? TO : k;
    if (clr0) begin m_to = 0; m_ovr = 0; end
    if (col) m_ovr = 1;
    for (int j = 1; j <= len; j++) begin
      if (clr_at == j) begin m_to = 0; m_ovr = 0; end
      if (xtrig_at == j) m_ovr = 1;
      if (timed && j == len) m_to = 1;
    end
    if (is_rd) m_rdata = timed ? RDATA_TIMEOUT : rd;
    m_lastrd = is_rd;
    m_count  = m_count + 8'd1;
    e.addr   = addr[AW-1:0];
    e.wdata  = wd;
    e.is_rd  = is_rd;
    e.len    = len;
    e.rdata  = m_rdata;
    e.status = {m_count, 4'b0000, m_lastrd, m_ovr, m_to, 1'b1};
    sb_q.push_back(e);
    n_exp++;

    cmd_addr  = addr;
    cmd_wdata = wd;
    trig_wr   = !is_rd;
    trig_rd   = is_rd || col;
    clr_flags = clr0;
    for (int j = 1; j <= len + 1; j++) begin
      @(negedge ti_clk);
      trig_wr = 0; trig_rd = 0; clr_flags = 0; bus_ack = 0;
      bus_rdata = 16'($urandom);
      cmd_addr  = 16'($urandom);
      cmd_wdata = 16'($urandom);
      if (j <= len) begin
        clr_flags = (clr_at == j);
        if (xtrig_at == j) begin
          if ($urandom_range(0, 1) == 1) trig_wr = 1;
          else                           trig_rd = 1;
        end
        if (j == k) begin bus_ack = 1; bus_rdata = rd; end
      end else if (noise) begin
        bus_ack = 1;
      end
    end
    @(negedge ti_clk);
    bus_ack = 0;
  endtask

  task automatic clr_idle();
    clr_flags = 1;
    @(negedge ti_clk);
    clr_flags = 0;
    m_to = 0; m_ovr = 0;
    chk("status_after_clr", {16'd0, status_wire},
        {16'd0, m_count, 4'b0000, m_lastrd, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_base;
    repeat (3) @(negedge ti_clk);
    chk("rst_bus_addr", {24'd0, bus_addr}, 32'd0);
    chk("rst_bus_wdata", {16'd0, bus_wdata}, 32'd0);
    chk("rst_strobes", {30'd0, bus_wr, bus_rd}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_wire}, 32'd0);
    chk("rst_status", {16'd0, status_wire}, 32'd0);
    chk("rst_done", {31'd0, done_trig}, 32'd0);
    rst = 0;
    @(negedge ti_clk);

    run_txn(0, 16'h0012, 16'hBEEF, 3, 16'h0000, 0, 0, 0, 0, 0);
    run_txn(1, 16'h0034, 16'h0000, 1, 16'h5A5A, 0, 0, 0, 0, 0);
    run_txn(1, 16'h0056, 16'h0000, TO + 1, 16'h1111, 0, 0, 0, 0, 1);
    clr_idle();
    run_txn(1, 16'hAB78, 16'h0000, TO, 16'h7777, 0, 0, 0, 0, 0);
    run_txn(0, 16'h009A, 16'hC0DE, 3, 16'h0000, 1, 0, 2, 0, 0);
    run_txn(0, 16'h0011, 16'h2222, 2, 16'h0000, 0, 0, 0, 0, 0);
    clr_idle();

    // Reset while strobing: no completion, everything back to zero
    cmd_addr = 16'h00F0; cmd_wdata = 16'h1234; trig_wr = 1;
    @(negedge ti_clk); trig_wr = 0;
    @(negedge ti_clk); rst = 1;
    @(negedge ti_clk);
    chk("midrst_strobe", {30'd0, bus_wr, bus_rd}, 32'd0);
    chk("midrst_done", {31'd0, done_trig}, 32'd0);
    chk("midrst_status", {16'd0, status_wire}, 32'd0);
    chk("midrst_addr", {24'd0, bus_addr}, 32'd0);
    @(negedge ti_clk); rst = 0;
    m_count = '0; m_to = 0; m_ovr = 0; m_lastrd = 0; m_rdata = '0;
    @(negedge ti_clk);

    done_base = done_cnt;
    for (int i = 0; i < 256; i++)
      run_txn(0, 16'($urandom), 16'($urandom), 1, 16'h0000, 0, 0, 0, 0, 0);
    chk("wrap_done_pulses", done_cnt - done_base, 256);
    chk("wrap_count", {24'd0, status_wire[15:8]}, 32'd0);

    for (int i = 0; i < 80; i++) begin
      int k, len, xt, ca;
      k   = $urandom_range(1, TO + 2);
      len = (k > TO) ? TO : k;
      xt  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      ca  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      run_txn(bit'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), k, 16'($urandom),
              bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 5) == 0), xt, ca,
              bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge ti_clk);
    end

    repeat (4) @(negedge ti_clk);
    chk("queue_drained", sb_q.size(), 0);
    chk("done_total", done_cnt, n_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/okregbus_ctrl.md
# okregbus_ctrl

Host-driven register-bus controller sitting between the FrontPanel endpoints (WireIns, TriggerIns, WireOuts, TriggerOut) and the design's internal register bus. The host loads address and data through WireIns, then fires a write or read trigger. The block runs a single strobed bus transaction with ack/timeout handling, then reports read data and sticky status back through WireOuts. It pulses a TriggerOut when the transaction completes.

## Interface
Parameters:
- ADDR_W, 8, register-bus address width (≤16)
- DATA_W, 16, register-bus data width (≤16)
- TIMEOUT, 255, maximum strobe cycles before abort (≥1, ≤65535)

Ports:
- ti_clk  in  1  host-interface clock; one clock domain only
- rst  in  1  synchronous, active-high reset
- cmd_addr  in  16  address WireIn; bits [ADDR_W-1:0] used
- cmd_wdata  in  16  write-data WireIn; bits [DATA_W-1:0] used
- trig_wr  in  1  single-cycle TriggerIn pulse: start write
- trig_rd  in  1  single-cycle TriggerIn pulse: start read
- clr_flags  in  1  single-cycle pulse: clear sticky flags
- bus_addr  out  ADDR_W  latched transaction address
- bus_wdata  out  DATA_W  latched write data
- bus_wr  out  1  write strobe, held until ack/timeout
- bus_rd  out  1  read strobe, held until ack/timeout
- bus_rdata  in  DATA_W  read data, valid when bus_ack=1
- bus_ack  in  1  transaction acknowledge
- rdata_wire  out  16  last read result, zero-extended, to WireOut
- status_wire  out  16  [0] busy, [1] timeout (sticky), [2] overrun (sticky), [3] last op was read, [7:4] 0, [15:8] completed-transaction count
- done_trig  out  1  single-cycle completion pulse to TriggerOut

## Operation
- FSM states: IDLE, STROBE, DONE.
- IDLE: on trig_wr, latch cmd_addr/cmd_wdata into bus_addr/bus_wdata, assert bus_wr, go to STROBE. Else on trig_rd, latch the address, assert bus_rd, go to STROBE.
- trig_wr and trig_rd together in IDLE: the write executes; the read is dropped and sets overrun.
- Any trigger outside IDLE: dropped, sets overrun.
- STROBE: the strobe stays high. On the first cycle with bus_ack=1:
  - Deassert the strobe.
  - For a read, capture bus_rdata into rdata_wire.
  - Go to DONE.
- STROBE timeout: if no ack after TIMEOUT strobe cycles:
  - Deassert the strobe.
  - Set the timeout flag.
  - For a read, rdata_wire = 16'hDEAD.
  - Go to DONE.
- DONE: done_trig=1 for exactly this cycle; update status bit [3] and increment the count (mod 256, 255→0). Timed-out transactions also count. Next state is IDLE.
- bus_ack outside STROBE: ignored.
- clr_flags clears bits [1] and [2]. If a set event occurs in the same cycle, set wins.
- Write transactions leave rdata_wire unchanged.
- Reset: all outputs 0, state IDLE, counters 0, flags 0. Reset mid-transaction drops the strobe the next cycle with no done_trig.

## Timing
- Trigger sampled at cycle 0 → strobe and busy high from cycle 1.
- Ack at cycle k (k≥1) → strobe low at k+1, done_trig at k+1, rdata_wire and status valid at k+1, busy low at k+2.
- Minimum transaction (ack at cycle 1): done_trig at cycle 2. The next trigger is accepted at cycle 3 at the earliest.
- Timeout: the strobe is high for exactly TIMEOUT cycles (1..TIMEOUT); done_trig at TIMEOUT+1.
- Ack arriving in the same cycle the timeout expires counts as ack; the timeout flag is not set.
- All outputs registered; no combinational input→output paths.

## Structure
- Package okregbus_pkg: FSM state enum; status bit index constants (ST_BUSY=0, ST_TIMEOUT=1, ST_OVERRUN=2, ST_LASTRD=3, ST_COUNT_LSB=8); RDATA_TIMEOUT=16'hDEAD.
- Sub-module okregbus_timeout: loadable down-counter with an expire flag, cleared on strobe start.
- Remaining FSM, latches and status logic live in okregbus_ctrl.

## Test plan
- Write: cmd_addr=0x12, cmd_wdata=0xBEEF, trig_wr; ack on the 3rd strobe cycle → bus_addr=0x12, bus_wdata=0xBEEF, bus_wr high for 3 cycles, one done_trig, count=1, status[3]=0.
- Read: cmd_addr=0x34, trig_rd; ack with bus_rdata=0x5A5A at cycle 1 → rdata_wire=0x5A5A at cycle 2, status[3]=1, done_trig at cycle 2.
- Timeout: TIMEOUT=4, read, no ack → bus_rd high for exactly 4 cycles, rdata_wire=0xDEAD, status[1]=1; clr_flags → status[1]=0.
- Collision: trig_wr+trig_rd same cycle, then trig_rd mid-STROBE → only the write runs, status[2]=1, count +1 only.
- Wrap: 256 back-to-back acked writes → count returns to 0; 256 done_trig pulses.
- Reset mid-STROBE → strobe low the next cycle, no done_trig, all status 0, next trigger serviced normally.
